// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the CPU control sequencer and its helpers.
//   - opcode values the sequencer has to recognise (loads, stores, breakpoint)
//   - FSM state encodings (also visible on the State debug port)
//   - sticky fault codes
//   - mem_kind(): classifies an opcode by the data-memory phase it needs
package cpu_pkg;

  localparam logic [6:0] OP_LD  = 7'd33;
  localparam logic [6:0] OP_ST  = 7'd34;
  localparam logic [6:0] OP_LDR = 7'd39;
  localparam logic [6:0] OP_STR = 7'd40;
  localparam logic [6:0] OP_BRK = 7'd41;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_DWAIT  = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEMRD  = 3'd4;
  localparam logic [2:0] ST_MEMWR  = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;
  localparam logic [2:0] ST_FAULT  = 3'd7;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_INVALID = 2'b01;
  localparam logic [1:0] FLT_BUS     = 2'b10;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_kind_e;

  function automatic mem_kind_e mem_kind(input logic [6:0] op);
    mem_kind_e k;
    k = MEM_NONE;
    if (op == OP_LD || op == OP_LDR) k = MEM_LOAD;
    else if (op == OP_ST || op == OP_STR) k = MEM_STORE;
    return k;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles spent waiting for a memory acknowledge.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   clr      in   restart the wait (count -> 0), takes priority over en
//   en       in   one more waiting cycle has elapsed
//   expired  out  high on the MEM_TIMEOUT-th cycle of the current wait
// The count holds at its last value so it can never wrap back to "not expired".
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  // Count value seen during the MEM_TIMEOUT-th waiting cycle (first cycle sees 0).
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer: fetch/decode/execute sequencer for the basic CPU.
// Owns the instruction-fetch handshake, pulses the decoder enable, issues the
// execute strobe and runs the data-memory phase for LD/ST/LDR/STR. Handles
// breakpoint halt/resume, decoder faults and memory timeouts, and counts
// retired instructions.
// Ports:
//   Clock     in   system clock (rising edge)
//   Reset_n   in   asynchronous active-low reset
//   MemReady  in   memory acknowledge, completes current access when high
//   OP[6:0]   in   opcode from decoder, valid from DWAIT onward
//   FLT       in   decoder invalid-instruction flag
//   Resume    in   leave HALT (level)
//   MemRead   out  memory read request
//   MemWrite  out  memory write request
//   AddrSel   out  0 = PC address, 1 = effective address
//   IRLoad    out  pulse: latch instruction register
//   PCInc     out  pulse: PC <= PC + 2
//   DecE      out  pulse: decoder enable
//   ExecEn    out  pulse: datapath executes decoded op
//   MemWB     out  pulse: write loaded data to destination
//   Halted    out  high while halted on a breakpoint
//   Fault     out  sticky fault code (00 none, 01 invalid instr, 10 bus timeout)
//   State     out  current state encoding (debug)
//   ICount    out  retired instruction count, wraps
module cpu_control_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int ICNT_W      = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              MemReady,
  input  logic [6:0]        OP,
  input  logic              FLT,
  input  logic              Resume,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              AddrSel,
  output logic              IRLoad,
  output logic              PCInc,
  output logic              DecE,
  output logic              ExecEn,
  output logic              MemWB,
  output logic              Halted,
  output logic [1:0]        Fault,
  output logic [2:0]        State,
  output logic [ICNT_W-1:0] ICount
);

  logic [2:0]        state_q, state_d;
  logic [1:0]        fault_q, fault_d;
  logic [ICNT_W-1:0] icount_q;
  logic              retire;
  logic              in_mem_state;
  logic              tmr_clr, tmr_en, tmr_expired;

  assign in_mem_state = (state_q == ST_FETCH) || (state_q == ST_MEMRD) ||
                        (state_q == ST_MEMWR);

  // Any state change restarts the wait, so every memory state is entered
  // with a fresh count; only unacknowledged cycles in a memory state count.
  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = in_mem_state && !MemReady;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // An acknowledge on the expiry cycle still completes the fetch.
        if (MemReady) begin
          state_d = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_FAULT;
          fault_d = FLT_BUS;
        end
      end
      ST_DECODE: state_d = ST_DWAIT;
      ST_DWAIT: begin
        if (FLT) begin
          state_d = ST_FAULT;
          fault_d = FLT_INVALID;
        end else if (OP == OP_BRK) begin
          // The breakpoint itself retires as it halts.
          retire  = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (mem_kind(OP))
          MEM_LOAD:  state_d = ST_MEMRD;
          MEM_STORE: state_d = ST_MEMWR;
          default: begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEMRD, ST_MEMWR: begin
        if (MemReady) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (tmr_expired) begin
          state_d = ST_FAULT;
          fault_d = FLT_BUS;
        end
      end
      ST_HALT: begin
        if (Resume) state_d = ST_FETCH;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_FETCH;
      fault_q  <= FLT_NONE;
      icount_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (retire) icount_q <= icount_q + ICNT_W'(1);
    end
  end

  // The reset state is FETCH, whose request and strobes would otherwise be
  // visible while Reset_n is low; gating with Reset_n keeps every output idle
  // from the instant reset asserts.
  logic fetch_live;
  assign fetch_live = Reset_n && (state_q == ST_FETCH);

  assign MemRead  = fetch_live || (state_q == ST_MEMRD);
  assign MemWrite = (state_q == ST_MEMWR);
  assign AddrSel  = (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
  assign IRLoad   = fetch_live && MemReady;
  assign PCInc    = fetch_live && MemReady;
  assign DecE     = (state_q == ST_DECODE);
  assign ExecEn   = (state_q == ST_EXEC);
  assign MemWB    = (state_q == ST_MEMRD) && MemReady;
  assign Halted   = (state_q == ST_HALT);
  assign Fault    = fault_q;
  assign State    = state_q;
  assign ICount   = icount_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: directed and randomized instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_cpu_control_sequencer;

  localparam int TO = 4;
  localparam int IW = 4;

  logic          Clock = 1'b0;
  logic          Reset_n;
  logic          MemReady;
  logic [6:0]    OP;
  logic          FLT;
  logic          Resume;
  logic          MemRead, MemWrite, AddrSel, IRLoad, PCInc, DecE, ExecEn, MemWB, Halted;
  logic [1:0]    Fault;
  logic [2:0]    State;
  logic [IW-1:0] ICount;

  int checks = 0;
  int errors = 0;
  int exp_retired = 0;
  int exp_fault = 0;

  always #5 Clock = ~Clock;

  cpu_control_sequencer #(
    .MEM_TIMEOUT(TO),
    .ICNT_W     (IW)
  ) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .MemReady(MemReady),
    .OP      (OP),
    .FLT     (FLT),
    .Resume  (Resume),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .AddrSel (AddrSel),
    .IRLoad  (IRLoad),
    .PCInc   (PCInc),
    .DecE    (DecE),
    .ExecEn  (ExecEn),
    .MemWB   (MemWB),
    .Halted  (Halted),
    .Fault   (Fault),
    .State   (State),
    .ICount  (ICount)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {MemRead, MemWrite, AddrSel, IRLoad, PCInc, DecE, ExecEn, MemWB, Halted};
  endfunction

  function automatic logic [8:0] ev(input bit rd, input bit wr, input bit as, input bit ir,
                                    input bit pc, input bit de, input bit ex, input bit wb,
                                    input bit h);
    return {rd, wr, as, ir, pc, de, ex, wb, h};
  endfunction

  task automatic next();
    @(posedge Clock);
    #1;
  endtask

  // Inputs for the cycle are already applied; check mid-cycle, then advance.
  task automatic check_cycle(input string tag, input logic [8:0] e, input int st);
    @(negedge Clock);
    chk({tag, "_outs"}, 32'(outs()), 32'(e));
    chk({tag, "_state"}, 32'(State), 32'(st));
    chk({tag, "_fault"}, 32'(Fault), 32'(exp_fault));
    chk({tag, "_icount"}, 32'(ICount), 32'(exp_retired % (1 << IW)));
    next();
  endtask

  // kind: 0 = instruction fetch, 1 = data read, 2 = data write.
  // Memory acknowledges on wait cycle dly+1; no ack within TO cycles is a bus fault.
  task automatic mem_phase(input int kind, input int dly, output bit acked);
    bit ack;
    acked = 1'b0;
    for (int i = 1; i <= TO && !acked; i++) begin
      MemReady = (i > dly);
      ack = MemReady;
      check_cycle(kind == 0 ? "fetch" : (kind == 1 ? "memrd" : "memwr"),
                  ev(kind != 2, kind == 2, kind != 0, kind == 0 && ack, kind == 0 && ack,
                     1'b0, 1'b0, kind == 1 && ack, 1'b0),
                  kind == 0 ? 0 : (kind == 1 ? 4 : 5));
      if (ack) acked = 1'b1;
    end
    if (!acked) exp_fault = 2;
    else if (kind != 0) exp_retired++;
  endtask

  task automatic do_instr(input logic [6:0] op, input bit flt, input int fdly, input int mdly,
                          input int hold, input bit abort_mem);
    bit ok;
    OP = op;
    FLT = flt;
    Resume = 1'b0;
    mem_phase(0, fdly, ok);
    if (!ok) return;
    MemReady = 1'($urandom);
    Resume = 1'($urandom);
    check_cycle("decode", ev(0, 0, 0, 0, 0, 1, 0, 0, 0), 1);
    MemReady = 1'($urandom);
    Resume = 1'($urandom);
    check_cycle("dwait", ev(0, 0, 0, 0, 0, 0, 0, 0, 0), 2);
    if (flt) begin
      exp_fault = 1;
      return;
    end
    if (op == 7'd41) begin
      exp_retired++;
      for (int i = 0; i < hold; i++) begin
        MemReady = 1'($urandom);
        Resume = 1'b0;
        check_cycle("halt", ev(0, 0, 0, 0, 0, 0, 0, 0, 1), 6);
      end
      Resume = 1'b1;
      check_cycle("halt_resume", ev(0, 0, 0, 0, 0, 0, 0, 0, 1), 6);
      return;
    end
    MemReady = 1'($urandom);
    Resume = 1'($urandom);
    check_cycle("exec", ev(0, 0, 0, 0, 0, 0, 1, 0, 0), 3);
    if (abort_mem) return;
    if (op == 7'd33 || op == 7'd39) mem_phase(1, mdly, ok);
    else if (op == 7'd34 || op == 7'd40) mem_phase(2, mdly, ok);
    else exp_retired++;
  endtask

  task automatic fault_hold(input int n);
    for (int i = 0; i < n; i++) begin
      MemReady = 1'($urandom);
      Resume = 1'b1;
      check_cycle("fault_hold", ev(0, 0, 0, 0, 0, 0, 0, 0, 0), 7);
    end
  endtask

  // Called 1 time unit after a rising edge; asserts reset between edges.
  task automatic apply_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rst_async_outs", 32'(outs()), 32'(0));
    chk("rst_async_state", 32'(State), 32'(0));
    chk("rst_async_fault", 32'(Fault), 32'(0));
    chk("rst_async_icount", 32'(ICount), 32'(0));
    MemReady = 1'b1;
    Resume = 1'b1;
    #1;
    chk("rst_ready_outs", 32'(outs()), 32'(0));
    next();
    Reset_n = 1'b1;
    Resume = 1'b0;
    exp_retired = 0;
    exp_fault = 0;
  endtask

  logic [6:0] op_tab [6];
  bit dummy;

  initial begin
    op_tab[0] = 7'd9;  op_tab[1] = 7'd33; op_tab[2] = 7'd34;
    op_tab[3] = 7'd39; op_tab[4] = 7'd40; op_tab[5] = 7'd41;
    Reset_n = 1'b0;
    MemReady = 1'b1;
    OP = 7'd0;
    FLT = 1'b0;
    Resume = 1'b0;
    #3;
    chk("reset_outs", 32'(outs()), 32'(0));
    chk("reset_state", 32'(State), 32'(0));
    chk("reset_fault", 32'(Fault), 32'(0));
    chk("reset_icount", 32'(ICount), 32'(0));
    next();
    Reset_n = 1'b1;

    // ALU op with no-wait memory, then loads/stores with waits, then a breakpoint.
    do_instr(7'd9, 1'b0, 0, 0, 0, 1'b0);
    chk("add_icount", 32'(ICount), 32'(1));
    chk("add_back_to_fetch", 32'(State), 32'(0));
    do_instr(7'd33, 1'b0, 0, 3, 0, 1'b0);
    do_instr(7'd34, 1'b0, 1, 2, 0, 1'b0);
    do_instr(7'd39, 1'b0, 2, 0, 0, 1'b0);
    do_instr(7'd40, 1'b0, 3, 3, 0, 1'b0);
    do_instr(7'd41, 1'b0, 0, 0, 2, 1'b0);
    do_instr(7'd9, 1'b0, 0, 0, 0, 1'b0);

    // Random stream, long enough to wrap the instruction counter.
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      if ($urandom_range(0, 3) == 0) op = 7'($urandom_range(0, 127));
      else op = op_tab[$urandom_range(0, 5)];
      do_instr(op, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
    end

    // Fetch never acknowledged: bus fault, terminal.
    do_instr(7'd9, 1'b0, TO, 0, 0, 1'b0);
    fault_hold(3);

    apply_reset();
    do_instr(7'd9, 1'b1, 1, 0, 0, 1'b0);
    fault_hold(3);

    apply_reset();
    do_instr(7'd33, 1'b0, 0, TO, 0, 1'b0);
    fault_hold(2);

    apply_reset();
    do_instr(7'd34, 1'b0, 0, TO, 0, 1'b0);
    fault_hold(2);

    // Reset while a load waits in the data-memory phase.
    apply_reset();
    do_instr(7'd9, 1'b0, 0, 0, 0, 1'b0);
    do_instr(7'd33, 1'b0, 0, 0, 0, 1'b1);
    MemReady = 1'b0;
    check_cycle("memrd_wait", ev(1, 0, 1, 0, 0, 0, 0, 0, 0), 4);
    apply_reset();
    do_instr(7'd9, 1'b0, 0, 0, 0, 1'b0);
    do_instr(7'd40, 1'b0, 1, 1, 0, 1'b0);
    dummy = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
